f_pc_unit: RTL and testbench
============================

F_PC_UNIT -- requirements
Module: f_pc_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-003 SHALL have port en  input  1  PC update enable; 0 = fetch stall (same stall signal that freezes the F/D register).
REQ-004 SHALL have port D_NPCSel  input  2  next-PC source from the D-stage instruction: 00 sequential, 01 conditional branch, 10 j/jal, 11 jr/jalr.
REQ-005 SHALL have port D_BranchTaken  input  1  branch comparison result for the D-stage instruction; used only when D_NPCSel=01.
REQ-006 SHALL have port D_PC4  input  32  PC+4 of the D-stage instruction.
REQ-007 SHALL have port D_Imm16  input  16  branch offset field.
REQ-008 SHALL have port D_Imm26  input  26  jump index field.
REQ-009 SHALL have port D_RsData  input  32  forwarded rs value for jr/jalr.
REQ-010 SHALL have port F_PC  output  32  address of the instruction being fetched this cycle.
REQ-011 SHALL have port F_RedirPending  output  1  a redirect captured during a stall is waiting to be applied.
REQ-012 SHALL have port F_AdEL  output  1  fetch address error flag for the current F_PC.

Function
REQ-013 SHALL define redirect-valid = (D_NPCSel=01 and D_BranchTaken) or D_NPCSel=10 or D_NPCSel=11.
REQ-014 SHALL compute branch target = D_PC4 + (sign-extended D_Imm16 shifted left 2), modulo 2^32.
REQ-015 SHALL compute jump target = {D_PC4[31:28], D_Imm26, 2'b00}.
REQ-016 SHALL use D_RsData unmodified as the jr/jalr target; no alignment masking.
REQ-017 SHALL treat D_NPCSel=01 with D_BranchTaken=0 as sequential.
REQ-018 SHALL use delayed-branch semantics: the instruction in F when the redirect is seen is the delay slot and is fetched normally; the next F_PC is the target.
REQ-019 SHALL hold three state registers: PC (32), pending flag (1), pending target (32).
REQ-020 SHALL, with en=1 and redirect-valid, load PC with the current redirect target, overriding any pending target.
REQ-021 SHALL, with en=1, no redirect-valid and pending=1, load PC with the pending target.
REQ-022 SHALL, with en=1, no redirect-valid and pending=0, load PC with PC+4 (wraps at 2^32).
REQ-023 SHALL clear pending on every cycle with en=1.
REQ-024 SHALL, with en=0, hold PC; if redirect-valid and pending=0, set pending and capture the target; if pending=1, keep the first captured target (later redirects during the same stall ignored).
REQ-025 SHALL drive F_PC directly from the PC register (zero combinational path from inputs to F_PC).
REQ-026 SHALL drive F_RedirPending directly from the pending flag.

Reset
REQ-027 SHALL, when reset=0 at a rising edge, set PC=0x0000_3000, pending=0, pending target=0x0000_0000, regardless of en or redirect inputs.
REQ-028 SHALL, after reset release, fetch 0x0000_3000 in the first cycle and advance per REQ-020..022 from the following edge.
REQ-029 SHALL discard any pending redirect on reset mid-stall.

Configuration
REQ-030 SHALL honor macro F_ADEL_CHECK_EN: when defined, F_AdEL=1 combinationally iff F_PC[1:0]!=00 or F_PC<0x0000_3000 or F_PC>0x0000_6FFC; else 0.
REQ-031 SHALL, without F_ADEL_CHECK_EN, tie F_AdEL to constant 0 and synthesize no comparison logic; all other behaviour identical.

Verification
REQ-032 SHALL cover reset: hold reset=0 two cycles with D_NPCSel=10 -> F_PC=0x3000, F_RedirPending=0; release, en=1, NPCSel=00 -> F_PC 0x3004, 0x3008.
REQ-033 SHALL cover branch: PC=0x3008, D_PC4=0x3008, D_Imm16=0xFFFE, NPCSel=01, Taken=1 -> next F_PC=0x3000; same with Taken=0 -> 0x300C.
REQ-034 SHALL cover jumps: D_PC4=0x3010, D_Imm26=0x0000C10, NPCSel=10 -> F_PC=0x3040; NPCSel=11, D_RsData=0x3100 -> F_PC=0x3100.
REQ-035 SHALL cover stall capture: PC=0x3020, en=0, NPCSel=11, RsData=0x3200 for 1 cycle, then RsData=0x3300 -> PC held 0x3020, pending=1; en=1 with NPCSel=00 -> F_PC=0x3200, pending=0.
REQ-036 SHALL cover priority and reset mid-stall: pending target 0x3200, en=1 with NPCSel=10 target 0x3400 -> F_PC=0x3400; separate run, reset=0 while pending=1 -> F_PC=0x3000, pending=0.
REQ-037 SHALL cover F_ADEL_CHECK_EN: jr to 0x3002 -> F_AdEL=1; jr to 0x7000 -> F_AdEL=1; 0x6FFC -> 0; macro undefined -> always 0.

Source files
------------

// File: rtl/f_pc_unit.sv
// ---------------------------------------------------------------------------
// f_pc_unit -- fetch-stage program counter with delayed-branch redirect
//
// Holds the fetch PC. When the D-stage instruction redirects (taken branch,
// j/jal, jr/jalr), the next fetch address becomes the redirect target. The
// instruction already in F at that time is the delay slot. If the fetch stage
// is stalled (en=0) when a redirect is seen, the first redirect target is
// captured and applied on the next enabled cycle.
//
// Ports
//   clk            in   1   sole clock, rising edge
//   reset          in   1   synchronous active-low reset
//   en             in   1   PC update enable (0 = fetch stall)
//   D_NPCSel       in   2   00 seq, 01 branch, 10 j/jal, 11 jr/jalr
//   D_BranchTaken  in   1   branch outcome, used only for D_NPCSel=01
//   D_PC4          in  32   PC+4 of the D-stage instruction
//   D_Imm16        in  16   branch offset field
//   D_Imm26        in  26   jump index field
//   D_RsData       in  32   forwarded rs value for jr/jalr
//   F_PC           out 32   fetch address (straight from the PC register)
//   F_RedirPending out  1   a redirect captured during a stall is waiting
//   F_AdEL         out  1   fetch address error for F_PC
//
// Configuration macro: F_ADEL_CHECK_EN
//   defined   -> F_AdEL flags misaligned PCs or PCs outside 0x3000..0x6FFC
//   undefined -> F_AdEL is tied to 0
// ---------------------------------------------------------------------------
module f_pc_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  D_NPCSel,
    input  logic        D_BranchTaken,
    input  logic [31:0] D_PC4,
    input  logic [15:0] D_Imm16,
    input  logic [25:0] D_Imm26,
    input  logic [31:0] D_RsData,
    output logic [31:0] F_PC,
    output logic        F_RedirPending,
    output logic        F_AdEL
);

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        pend_q;
    logic        pend_d;
    logic [31:0] pend_tgt_q;
    logic [31:0] pend_tgt_d;

    logic        redir_valid_s;
    logic [31:0] redir_tgt_s;
    logic [31:0] br_tgt_s;
    logic [31:0] j_tgt_s;

    // Redirect target candidates from the D-stage fields
    always_comb begin
        br_tgt_s = D_PC4 + {{14{D_Imm16[15]}}, D_Imm16, 2'b00};
        j_tgt_s  = {D_PC4[31:28], D_Imm26, 2'b00};
    end

    // Redirect decode; a not-taken branch behaves as sequential
    always_comb begin
        redir_valid_s = 1'b0;
        redir_tgt_s   = 32'h0000_0000;
        case (D_NPCSel)
            2'b00: begin
                redir_valid_s = 1'b0;
                redir_tgt_s   = 32'h0000_0000;
            end
            2'b01: begin
                redir_valid_s = D_BranchTaken;
                redir_tgt_s   = br_tgt_s;
            end
            2'b10: begin
                redir_valid_s = 1'b1;
                redir_tgt_s   = j_tgt_s;
            end
            2'b11: begin
                redir_valid_s = 1'b1;
                redir_tgt_s   = D_RsData;
            end
            default: begin
                redir_valid_s = 1'b0;
                redir_tgt_s   = 32'h0000_0000;
            end
        endcase
    end

    // Next-state for PC and the stall-time pending redirect
    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        if (en) begin
            // Any enabled cycle consumes the pending redirect; a live
            // redirect from D is newer and wins over it.
            pend_d = 1'b0;
            if (redir_valid_s) begin
                pc_d = redir_tgt_s;
            end else if (pend_q) begin
                pc_d = pend_tgt_q;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end else begin
            // Stalled: D holds the same instruction, so only the first
            // redirect seen during the stall is captured.
            if (redir_valid_s && !pend_q) begin
                pend_d     = 1'b1;
                pend_tgt_d = redir_tgt_s;
            end else begin
                pend_d     = pend_q;
                pend_tgt_d = pend_tgt_q;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0000_0000;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign F_PC           = pc_q;
    assign F_RedirPending = pend_q;

`ifdef F_ADEL_CHECK_EN
    // Legal fetch window is word-aligned 0x3000..0x6FFC
    always_comb begin
        F_AdEL = (pc_q[1:0] != 2'b00) ||
                 (pc_q < 32'h0000_3000) ||
                 (pc_q > 32'h0000_6FFC);
    end
`else
    assign F_AdEL = 1'b0;
`endif

endmodule

// File: tb/tb_f_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_f_pc_unit -- directed self-checking bench for f_pc_unit
// Inputs change #1 after a rising edge; outputs are sampled #1 after the
// next rising edge, so every check sees the state loaded by that edge.
// ---------------------------------------------------------------------------
module tb_f_pc_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [1:0]  D_NPCSel;
    logic        D_BranchTaken;
    logic [31:0] D_PC4;
    logic [15:0] D_Imm16;
    logic [25:0] D_Imm26;
    logic [31:0] D_RsData;
    logic [31:0] F_PC;
    logic        F_RedirPending;
    logic        F_AdEL;

    int checks;
    int failures;

    f_pc_unit dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .D_NPCSel       (D_NPCSel),
        .D_BranchTaken  (D_BranchTaken),
        .D_PC4          (D_PC4),
        .D_Imm16        (D_Imm16),
        .D_Imm26        (D_Imm26),
        .D_RsData       (D_RsData),
        .F_PC           (F_PC),
        .F_RedirPending (F_RedirPending),
        .F_AdEL         (F_AdEL)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [1:0] sel, input logic tk,
                         input logic [31:0] pc4, input logic [15:0] i16,
                         input logic [25:0] i26, input logic [31:0] rs);
        en            = e;
        D_NPCSel      = sel;
        D_BranchTaken = tk;
        D_PC4         = pc4;
        D_Imm16       = i16;
        D_Imm26       = i26;
        D_RsData      = rs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected F_AdEL for a given PC, depending on build configuration
    function automatic logic [31:0] adel_exp(input logic [31:0] pc);
`ifdef F_ADEL_CHECK_EN
        return {31'd0, (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC)};
`else
        return {31'd0, 1'b0 & pc[0]};
`endif
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        // Reset held two cycles while D presents a jump
        reset = 1'b0;
        drive(1'b1, 2'b10, 1'b0, 32'h0000_3010, 16'h0000, 26'h0000C10, 32'h0000_0000);
        step();
        step();
        check_eq("reset_pc", F_PC, 32'h0000_3000);
        check_eq("reset_pend", {31'd0, F_RedirPending}, 32'd0);
        check_eq("reset_adel", {31'd0, F_AdEL}, 32'd0);

        // Release: sequential fetch
        reset = 1'b1;
        drive(1'b1, 2'b00, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_0000);
        step();
        check_eq("seq_3004", F_PC, 32'h0000_3004);
        step();
        check_eq("seq_3008", F_PC, 32'h0000_3008);

        // Taken branch backwards: 0x3008 + (-2 << 2) = 0x3000
        drive(1'b1, 2'b01, 1'b1, 32'h0000_3008, 16'hFFFE, 26'h0, 32'h0000_0000);
        step();
        check_eq("br_taken", F_PC, 32'h0000_3000);

        // Walk back to 0x3008, then not-taken branch falls through
        drive(1'b1, 2'b00, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_0000);
        step();
        step();
        check_eq("walk_3008", F_PC, 32'h0000_3008);
        drive(1'b1, 2'b01, 1'b0, 32'h0000_3008, 16'hFFFE, 26'h0, 32'h0000_0000);
        step();
        check_eq("br_not_taken", F_PC, 32'h0000_300C);

        // Stall with no redirect holds PC
        drive(1'b0, 2'b00, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_0000);
        step();
        check_eq("stall_hold", F_PC, 32'h0000_300C);
        check_eq("stall_nopend", {31'd0, F_RedirPending}, 32'd0);

        // j: {0x0, 0xC10, 00} = 0x3040
        drive(1'b1, 2'b10, 1'b0, 32'h0000_3010, 16'h0000, 26'h0000C10, 32'h0000_0000);
        step();
        check_eq("jump", F_PC, 32'h0000_3040);
        // jr
        drive(1'b1, 2'b11, 1'b0, 32'h0000_3010, 16'h0000, 26'h0, 32'h0000_3100);
        step();
        check_eq("jr", F_PC, 32'h0000_3100);

        // Stall capture: get to 0x3020 first
        drive(1'b1, 2'b11, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_3020);
        step();
        check_eq("jr_3020", F_PC, 32'h0000_3020);
        drive(1'b0, 2'b11, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_3200);
        step();
        check_eq("cap_hold", F_PC, 32'h0000_3020);
        check_eq("cap_pend", {31'd0, F_RedirPending}, 32'd1);
        drive(1'b0, 2'b11, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_3300);
        step();
        check_eq("cap_hold2", F_PC, 32'h0000_3020);
        check_eq("cap_pend2", {31'd1 & 31'd0, F_RedirPending}, 32'd1);
        drive(1'b1, 2'b00, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_0000);
        step();
        check_eq("cap_apply", F_PC, 32'h0000_3200);
        check_eq("cap_clear", {31'd0, F_RedirPending}, 32'd0);

        // Live redirect overrides pending target
        drive(1'b0, 2'b11, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_3200);
        step();
        check_eq("prio_pend", {31'd0, F_RedirPending}, 32'd1);
        drive(1'b1, 2'b10, 1'b0, 32'h0000_3000, 16'h0000, 26'h0000D00, 32'h0000_0000);
        step();
        check_eq("prio_pc", F_PC, 32'h0000_3400);
        check_eq("prio_clear", {31'd0, F_RedirPending}, 32'd0);

        // Reset mid-stall discards the pending redirect
        drive(1'b0, 2'b11, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_3500);
        step();
        check_eq("rst_mid_pend", {31'd0, F_RedirPending}, 32'd1);
        reset = 1'b0;
        step();
        check_eq("rst_mid_pc", F_PC, 32'h0000_3000);
        check_eq("rst_mid_clear", {31'd0, F_RedirPending}, 32'd0);
        reset = 1'b1;
        drive(1'b1, 2'b00, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_0000);
        step();
        check_eq("rst_mid_seq", F_PC, 32'h0000_3004);

        // Fetch address error window
        drive(1'b1, 2'b11, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_3002);
        step();
        check_eq("jr_3002", F_PC, 32'h0000_3002);
        check_eq("adel_misalign", {31'd0, F_AdEL}, adel_exp(32'h0000_3002));
        drive(1'b1, 2'b11, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_7000);
        step();
        check_eq("adel_high", {31'd0, F_AdEL}, adel_exp(32'h0000_7000));
        drive(1'b1, 2'b11, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_6FFC);
        step();
        check_eq("adel_edge", {31'd0, F_AdEL}, adel_exp(32'h0000_6FFC));
        drive(1'b1, 2'b11, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_2FFC);
        step();
        check_eq("adel_low", {31'd0, F_AdEL}, adel_exp(32'h0000_2FFC));

        // Sequential wrap at 2^32
        drive(1'b1, 2'b11, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'hFFFF_FFFC);
        step();
        check_eq("jr_top", F_PC, 32'hFFFF_FFFC);
        drive(1'b1, 2'b00, 1'b0, 32'h0000_0000, 16'h0000, 26'h0, 32'h0000_0000);
        step();
        check_eq("wrap", F_PC, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
